// File: rtl/aer_pkg.sv
// Shared types and helpers for the AER event transmitter.
package aer_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ARM,
      ST_PRIME,
      ST_SETTLE,
      ST_CHECK,
      ST_REQ_HI,
      ST_REQ_LO,
      ST_DUMP,
      ST_DONE
   } aer_tx_state_e;

   localparam int unsigned ONEHOT_MAX_W = 64;

   // True when exactly one bit is set; callers zero-extend narrower vectors.
   function automatic logic onehot_is_valid(input logic [ONEHOT_MAX_W-1:0] v);
      return (v != '0) && ((v & (v - ONEHOT_MAX_W'(1))) == '0);
   endfunction

endpackage

// File: rtl/aer_event_tx_onehot_to_bin.sv
// Combinational one-hot to binary index encoder with validity flags.
import aer_pkg::*;

module onehot_to_bin #(
   parameter int unsigned N_CH = 16,
   localparam int unsigned AW = $clog2(N_CH)
) (
   input  logic [N_CH-1:0] onehot_i,
   output logic [AW-1:0]   bin_o,
   output logic            valid_o,
   output logic            none_o
);

   always_comb begin
      bin_o = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         if (onehot_i[i]) bin_o = bin_o | AW'(i);
      end
   end

   assign valid_o = onehot_is_valid(ONEHOT_MAX_W'(onehot_i));
   assign none_o  = (onehot_i == '0);

endmodule

// File: rtl/aer_event_tx.sv
// Drains the channel priority scanner one event at a time over a 4-phase AER link.
import aer_pkg::*;

module aer_event_tx #(
   parameter int unsigned N_CH       = 16,
   parameter int unsigned ARM_CYCLES = 1,
   parameter bit          PRIME_DUMP = 1'b1,
   parameter int unsigned TIMEOUT    = 255,
   localparam int unsigned AW = $clog2(N_CH)
) (
   input  logic            clk_i,
   input  logic            resetn_i,
   input  logic            frame_start_i,
   input  logic [N_CH-1:0] ch_sel_i,
   input  logic            zero_i,
   output logic            arm_o,
   output logic            dump_o,
   output logic            aer_req_o,
   output logic [AW-1:0]   aer_addr_o,
   input  logic            aer_ack_i,
   output logic            busy_o,
   output logic            frame_done_o,
   output logic [AW:0]     event_cnt_o,
   output logic            err_onehot_o,
   output logic            err_timeout_o
);

   localparam int unsigned CNT_MAX = (ARM_CYCLES > TIMEOUT) ? ARM_CYCLES : TIMEOUT;
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);
   localparam int unsigned EVW     = AW + 1;
   localparam logic [CW-1:0]  ARM_LAST = CW'(ARM_CYCLES - 1);
   localparam logic [CW-1:0]  TO_LAST  = CW'(TIMEOUT - 1);
   localparam logic [EVW-1:0] EV_MAX   = EVW'(N_CH);

   aer_tx_state_e  state_q, state_d;
   logic           ack_s1_q, ack_s2_q;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [AW-1:0]  addr_q, addr_d;
   logic [EVW-1:0] evcnt_q, evcnt_d;
   logic           err_oh_q, err_oh_d;
   logic           err_to_q, err_to_d;
   logic           req_q, req_d;

   logic [AW-1:0]  sel_bin;
   logic           sel_valid, sel_none;
   logic           ack_sync, sel_empty, frame_go;

   onehot_to_bin #(.N_CH(N_CH)) u_onehot_to_bin (
      .onehot_i (ch_sel_i),
      .bin_o    (sel_bin),
      .valid_o  (sel_valid),
      .none_o   (sel_none)
   );

   assign ack_sync  = ack_s2_q;
   assign sel_empty = zero_i | sel_none;
   assign frame_go  = (state_q == ST_IDLE) && frame_start_i;

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) state_q <= ST_IDLE;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:   if (frame_start_i) state_d = ST_ARM;
         ST_ARM:    if (cnt_q == ARM_LAST) state_d = PRIME_DUMP ? ST_PRIME : ST_SETTLE;
         ST_PRIME:  state_d = ST_SETTLE;
         ST_SETTLE: state_d = ST_CHECK;
         ST_CHECK: begin
            if (sel_empty || !sel_valid) state_d = ST_DONE;
            else if (!ack_sync)          state_d = ST_REQ_HI;
         end
         ST_REQ_HI: begin
            if (ack_sync)              state_d = ST_REQ_LO;
            else if (cnt_q == TO_LAST) state_d = ST_DONE;
         end
         ST_REQ_LO: begin
            if (!ack_sync)             state_d = ST_DUMP;
            else if (cnt_q == TO_LAST) state_d = ST_DONE;
         end
         ST_DUMP:   state_d = ST_SETTLE;
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Request is registered from the next state so the off-chip line never glitches.
   always_comb begin
      arm_o        = (state_q == ST_ARM);
      dump_o       = (state_q == ST_PRIME) || (state_q == ST_DUMP);
      busy_o       = (state_q != ST_IDLE);
      frame_done_o = (state_q == ST_DONE);
      req_d        = (state_d == ST_REQ_HI);
      cnt_d        = (state_d != state_q) ? '0 :
                     (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
      addr_d       = ((state_q == ST_CHECK) && (state_d == ST_REQ_HI)) ? sel_bin : addr_q;
      evcnt_d      = evcnt_q;
      err_oh_d     = err_oh_q;
      err_to_d     = err_to_q;
      if (frame_go) begin
         evcnt_d  = '0;
         err_oh_d = 1'b0;
         err_to_d = 1'b0;
      end
      if ((state_q == ST_DUMP) && (evcnt_q != EV_MAX)) evcnt_d = evcnt_q + EVW'(1);
      if ((state_q == ST_CHECK) && !sel_empty && !sel_valid) err_oh_d = 1'b1;
      if (((state_q == ST_REQ_HI) || (state_q == ST_REQ_LO)) && (state_d == ST_DONE))
         err_to_d = 1'b1;
   end

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         ack_s1_q <= 1'b0;
         ack_s2_q <= 1'b0;
         cnt_q    <= '0;
         addr_q   <= '0;
         evcnt_q  <= '0;
         err_oh_q <= 1'b0;
         err_to_q <= 1'b0;
         req_q    <= 1'b0;
      end else begin
         ack_s1_q <= aer_ack_i;
         ack_s2_q <= ack_s1_q;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         evcnt_q  <= evcnt_d;
         err_oh_q <= err_oh_d;
         err_to_q <= err_to_d;
         req_q    <= req_d;
      end
   end

   assign aer_req_o     = req_q;
   assign aer_addr_o    = addr_q;
   assign event_cnt_o   = evcnt_q;
   assign err_onehot_o  = err_oh_q;
   assign err_timeout_o = err_to_q;

endmodule
